// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter: FSM state encoding and
// the rotating-priority pick used to choose the next producer.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST    = 2'd1,
        CLR_WAIT = 2'd2,
        CLR      = 2'd3
    } state_t;

    localparam int MAX_REQ = 8;

    // First valid index at or above ptr, wrapping at nreq; returns ptr when none are valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic [2:0] pick;
        int         idx;
        pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (valid[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: picks the first valid producer
// starting at the round-robin pointer and wrapping past the top index.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [GW-1:0]   i_ptr,
    output logic [GW-1:0]   o_pick
);

    logic [MAX_REQ-1:0] w_valid_pad;
    logic [2:0]         w_ptr_pad;
    logic [2:0]         w_pick_full;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_pad
            if (gi < NREQ) begin : g_used
                assign w_valid_pad[gi] = i_valid[gi];
            end else begin : g_unused
                assign w_valid_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_ptr_pad   = 3'(i_ptr);
    assign w_pick_full = rr_pick(w_valid_pad, w_ptr_pad, NREQ);
    assign o_pick      = GW'(w_pick_full);

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready
// producers, with per-grant burst limit and a sequenced FIFO clear.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int TAM   = 32,
    parameter int SIZE  = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic [NREQ-1:0]           REQ_VALID,
    input  logic [NREQ*SIZE-1:0]      REQ_DATA,
    output logic [NREQ-1:0]           REQ_READY,
    output logic [$clog2(NREQ)-1:0]   GRANT_ID,
    input  logic                      CLEAR_REQ,
    output logic                      CLEAR_DONE,
    input  logic                      F_FULL_N,
    input  logic                      F_EMPTY_N,
    input  logic [$clog2(TAM-1)-1:0]  USE_DW,
    output logic                      FIFO_WRITE,
    output logic [SIZE-1:0]           FIFO_DATA,
    output logic                      FIFO_CLEAR_N
);

    localparam int GW = $clog2(NREQ);
    localparam int OW = $clog2(TAM) + 1;
    localparam int CW = $clog2(BURST + 1);

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;
    logic            r_write;
    logic [SIZE-1:0] r_data;
    logic            r_clear_n;
    logic            r_done;

    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_ptr_next;
    logic [OW-1:0]   w_occ;
    logic [OW-1:0]   w_load;
    logic            w_space;
    logic [NREQ-1:0] w_ready;
    logic            w_xfer;
    logic            w_last;
    logic            w_gvalid;
    logic [SIZE-1:0] w_word;
    logic            w_unused;

    // Occupancy comes from USE_DW/F_FULL_N; the empty flag is not needed.
    assign w_unused = F_EMPTY_N;

    rr_priority_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .i_valid (REQ_VALID),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick)
    );

    // USE_DW wraps to zero when full, so a full FIFO is reported as TAM words.
    // The registered write still in flight is not yet visible in USE_DW.
    assign w_occ   = F_FULL_N ? OW'(USE_DW) : OW'(TAM);
    assign w_load  = w_occ + OW'(r_write);
    assign w_space = (w_load < OW'(TAM));

    always_comb begin
        w_ready = '0;
        if (r_state == fifo_arb_pkg::BURST && w_space && !CLEAR_REQ) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    assign w_xfer     = |(w_ready & REQ_VALID);
    assign w_last     = (r_count == CW'(BURST - 1));
    assign w_gvalid   = REQ_VALID[r_grant];
    assign w_word     = REQ_DATA[r_grant*SIZE +: SIZE];
    assign w_ptr_next = (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + GW'(1);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state   <= fifo_arb_pkg::IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_count   <= '0;
            r_write   <= 1'b0;
            r_data    <= '0;
            r_clear_n <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_write   <= 1'b0;
            r_clear_n <= 1'b1;
            r_done    <= 1'b0;
            case (r_state)
                fifo_arb_pkg::IDLE: begin
                    if (CLEAR_REQ) begin
                        r_state <= fifo_arb_pkg::CLR_WAIT;
                    end else if (|REQ_VALID) begin
                        r_grant <= w_pick;
                        r_count <= '0;
                        r_state <= fifo_arb_pkg::BURST;
                    end
                end
                fifo_arb_pkg::BURST: begin
                    if (w_xfer) begin
                        r_write <= 1'b1;
                        r_data  <= w_word;
                        r_count <= r_count + CW'(1);
                    end
                    // A full-FIFO stall keeps the grant; only these end it.
                    if ((w_xfer && w_last) || !w_gvalid || CLEAR_REQ) begin
                        r_state <= fifo_arb_pkg::IDLE;
                        r_ptr   <= w_ptr_next;
                    end
                end
                fifo_arb_pkg::CLR_WAIT: begin
                    if (!r_write) begin
                        r_state   <= fifo_arb_pkg::CLR;
                        r_clear_n <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                fifo_arb_pkg::CLR: begin
                    r_state <= fifo_arb_pkg::IDLE;
                end
                default: begin
                    r_state <= fifo_arb_pkg::IDLE;
                end
            endcase
        end
    end

    assign REQ_READY    = w_ready;
    assign GRANT_ID     = r_grant;
    assign CLEAR_DONE   = r_done;
    assign FIFO_WRITE   = r_write;
    assign FIFO_DATA    = r_data;
    assign FIFO_CLEAR_N = r_clear_n;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: a behavioural 32x8 FIFO sits
// behind the main instance; a second BURST=1 instance checks write cadence.
module tb_fifo_write_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        clear_req;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        clear_done;
    logic        fifo_write;
    logic [7:0]  fifo_data;
    logic        fifo_clear_n;

    // FIFO model
    logic [5:0]  f_count;
    logic        f_read;
    logic        f_full_n;
    logic        f_empty_n;
    logic [4:0]  use_dw;
    int          full_writes = 0;
    logic [7:0]  wlog[$];

    // second instance, BURST=1
    logic [3:0]  v1_valid;
    logic [31:0] v1_data;
    logic [3:0]  v1_ready;
    logic [1:0]  v1_grant;
    logic        v1_done;
    logic        v1_write;
    logic [7:0]  v1_fdata;
    logic        v1_clear_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    fifo_write_arbiter #(.TAM(32), .SIZE(8), .NREQ(4), .BURST(4)) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .REQ_VALID    (req_valid),
        .REQ_DATA     (req_data),
        .REQ_READY    (req_ready),
        .GRANT_ID     (grant_id),
        .CLEAR_REQ    (clear_req),
        .CLEAR_DONE   (clear_done),
        .F_FULL_N     (f_full_n),
        .F_EMPTY_N    (f_empty_n),
        .USE_DW       (use_dw),
        .FIFO_WRITE   (fifo_write),
        .FIFO_DATA    (fifo_data),
        .FIFO_CLEAR_N (fifo_clear_n)
    );

    fifo_write_arbiter #(.TAM(32), .SIZE(8), .NREQ(4), .BURST(1)) dut1 (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .REQ_VALID    (v1_valid),
        .REQ_DATA     (v1_data),
        .REQ_READY    (v1_ready),
        .GRANT_ID     (v1_grant),
        .CLEAR_REQ    (1'b0),
        .CLEAR_DONE   (v1_done),
        .F_FULL_N     (1'b1),
        .F_EMPTY_N    (1'b0),
        .USE_DW       (5'd0),
        .FIFO_WRITE   (v1_write),
        .FIFO_DATA    (v1_fdata),
        .FIFO_CLEAR_N (v1_clear_n)
    );

    // Behavioural FIFO32x8 occupancy: synchronous clear, writes ignored when full.
    always_ff @(posedge CLOCK) begin
        if (RESET || !fifo_clear_n) begin
            f_count <= 6'd0;
        end else begin
            f_count <= f_count
                       + ((fifo_write && f_count != 6'd32) ? 6'd1 : 6'd0)
                       - ((f_read && f_count != 6'd0) ? 6'd1 : 6'd0);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (fifo_write && f_count == 6'd32 && fifo_clear_n) begin
            full_writes <= full_writes + 1;
        end
    end

    assign f_full_n  = (f_count != 6'd32);
    assign f_empty_n = (f_count != 6'd0);
    assign use_dw    = f_count[4:0];

    always @(negedge CLOCK) begin
        if (fifo_write) wlog.push_back(fifo_data);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        clr;
        logic [3:0]  rdy;
        logic        w;
        logic [7:0]  d;
        logic [1:0]  g;
        logic        cn;
        logic        dn;
    } vec_t;

    vec_t vt[14];

    initial begin
        int cnt[4];
        int k;
        int acc;
        int nw;
        logic [3:0] hs;
        logic prev_w;
        logic [7:0] exp_b;

        // short burst req2, hand-over to req3, burst on req0 cut by a clear
        vt[0]  = '{4'b0100, 32'h0020_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0};
        vt[1]  = '{4'b0100, 32'h0020_0000, 1'b0, 4'b0100, 1'b1, 8'h20, 2'd2, 1'b1, 1'b0};
        vt[2]  = '{4'b0100, 32'h0021_0000, 1'b0, 4'b0100, 1'b1, 8'h21, 2'd2, 1'b1, 1'b0};
        vt[3]  = '{4'b1000, 32'h3000_0000, 1'b0, 4'b0100, 1'b0, 8'h21, 2'd2, 1'b1, 1'b0};
        vt[4]  = '{4'b1000, 32'h3000_0000, 1'b0, 4'b0000, 1'b0, 8'h21, 2'd3, 1'b1, 1'b0};
        vt[5]  = '{4'b1000, 32'h3000_0000, 1'b0, 4'b1000, 1'b1, 8'h30, 2'd3, 1'b1, 1'b0};
        vt[6]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b1000, 1'b0, 8'h30, 2'd3, 1'b1, 1'b0};
        vt[7]  = '{4'b0001, 32'h0000_0005, 1'b0, 4'b0000, 1'b0, 8'h30, 2'd0, 1'b1, 1'b0};
        vt[8]  = '{4'b0001, 32'h0000_0005, 1'b0, 4'b0001, 1'b1, 8'h05, 2'd0, 1'b1, 1'b0};
        vt[9]  = '{4'b0001, 32'h0000_0006, 1'b0, 4'b0001, 1'b1, 8'h06, 2'd0, 1'b1, 1'b0};
        vt[10] = '{4'b0001, 32'h0000_0007, 1'b1, 4'b0000, 1'b0, 8'h06, 2'd0, 1'b1, 1'b0};
        vt[11] = '{4'b0001, 32'h0000_0007, 1'b1, 4'b0000, 1'b0, 8'h06, 2'd0, 1'b1, 1'b0};
        vt[12] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h06, 2'd0, 1'b0, 1'b1};
        vt[13] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h06, 2'd0, 1'b1, 1'b0};

        RESET = 1'b1; req_valid = '0; req_data = '0; clear_req = 1'b0; f_read = 1'b0;
        v1_valid = '0; v1_data = '0;
        tick(); tick();
        check("rst_write", fifo_write, 0);
        check("rst_data", fifo_data, 0);
        check("rst_clear_n", fifo_clear_n, 1);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_done", clear_done, 0);
        $display("reset: write=%b data=%h clear_n=%b ready=%b grant=%0d", fifo_write, fifo_data, fifo_clear_n, req_ready, grant_id);
        RESET = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req_valid = vt[i].valid; req_data = vt[i].data; clear_req = vt[i].clr;
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, vt[i].rdy);
            tick();
            check($sformatf("vec%0d_out", i),
                  {fifo_write, fifo_data, grant_id, fifo_clear_n, clear_done},
                  {vt[i].w, vt[i].d, vt[i].g, vt[i].cn, vt[i].dn});
            $display("vec %0d: valid=%b clr=%b write=%b data=%h grant=%0d clear_n=%b done=%b",
                     i, vt[i].valid, vt[i].clr, fifo_write, fifo_data, grant_id, fifo_clear_n, clear_done);
        end
        check("clr_empty_n", f_empty_n, 0);
        check("clr_use_dw", use_dw, 0);
        check("clr_logged_words", wlog.size(), 5);
        if (wlog.size() == 5) check("clr_inflight_word", wlog[4], 8'h06);

        // reset in the middle of a burst from requester 1
        k = 0;
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            req_data = 32'((8'h10 + k) & 8'hff) << 8;
            #1;
            if (req_ready[1]) k++;
            tick();
        end
        check("stream_started", (k > 0), 1);
        RESET = 1'b1;
        tick();
        check("midrst_out", {fifo_write, fifo_data, grant_id, fifo_clear_n, clear_done, req_ready},
              {1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 4'b0000});
        $display("mid-burst reset after %0d words: write=%b grant=%0d", k, fifo_write, grant_id);
        tick();
        req_valid = '0;
        RESET = 1'b0;

        // round robin, all four requesters valid; pointer restarts at 0
        wlog.delete();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        req_valid = 4'hF;
        for (int c = 0; c < 200 && wlog.size() < 16; c++) begin
            for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'((i << 4) | (cnt[i] & 15));
            #1;
            hs = req_ready & req_valid;
            tick();
            for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
        end
        req_valid = '0;
        check("rr_word_count", (wlog.size() >= 16), 1);
        for (int j = 0; j < 16 && j < wlog.size(); j++) begin
            exp_b = 8'(((j / 4) << 4) | (j % 4));
            check($sformatf("rr_word%0d", j), wlog[j], exp_b);
            $display("rr word %0d: data=%h", j, wlog[j]);
        end

        // full boundary: requester 0 offers more than the FIFO holds
        RESET = 1'b1; tick(); RESET = 1'b0;
        acc = 0;
        req_valid = 4'b0001;
        for (int c = 0; c < 100; c++) begin
            req_data = 32'(acc & 255);
            #1;
            if (req_ready[0]) acc++;
            tick();
        end
        #1;
        check("full_accepted", acc, 32);
        check("full_flag_n", f_full_n, 0);
        check("full_ready", req_ready, 0);
        $display("full: accepted=%0d full_n=%b", acc, f_full_n);
        f_read = 1'b1; tick(); f_read = 1'b0;
        for (int c = 0; c < 20; c++) begin
            req_data = 32'(acc & 255);
            #1;
            if (req_ready[0]) acc++;
            tick();
        end
        req_valid = '0;
        check("after_read_accepted", acc, 33);
        check("after_read_full_n", f_full_n, 0);
        check("write_while_full", full_writes, 0);
        $display("after one read: accepted=%0d full_n=%b", acc, f_full_n);

        // BURST=1 instance: one word every other cycle, in order
        k = 0; nw = 0; prev_w = 1'b0;
        v1_valid = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            v1_data = 32'((8'h40 + k) & 8'hff);
            #1;
            hs = v1_ready & v1_valid;
            tick();
            if (hs[0]) k++;
            if (v1_write) begin
                check($sformatf("b1_word%0d", nw), v1_fdata, 8'(8'h40 + nw));
                $display("burst1 word %0d: data=%h", nw, v1_fdata);
                nw++;
            end
            check($sformatf("b1_back_to_back_c%0d", c), (prev_w && v1_write), 0);
            prev_w = v1_write;
        end
        v1_valid = '0;
        check("b1_write_count", nw, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
